// File: rtl/bus_select_arbiter.sv
// Round-robin owner selection for the shared 32-bit datapath mux.
// Drives mux select, a valid/ready beat window and a turnaround cycle between owners.
module bus_select_arbiter #(
    parameter int NREQ      = 8,
    parameter int MAX_BURST = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [NREQ-1:0] Req,
    input  logic [NREQ-1:0] Last,
    input  logic            BusReady,
    output logic [NREQ-1:0] Grant,
    output logic [2:0]      MuxSel,
    output logic            BusValid,
    output logic            Busy
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        TURN
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [NREQ-1:0] grant_n;
    logic [2:0]      sel_n;
    logic [2:0]      ptr;
    logic [2:0]      ptr_n;
    logic [2:0]      win;
    logic            found;
    logic            busy_n;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_n;
    logic [7:0]      req8;
    logic [7:0]      last8;
    logic            own_req;
    logic            own_last;
    logic            accept;
    logic            at_max;

    function automatic logic [2:0] wrap(input logic [3:0] v);
        return (v >= 4'(NREQ)) ? 3'(v - 4'(NREQ)) : v[2:0];
    endfunction

    assign req8     = 8'(Req);
    assign last8    = 8'(Last);
    assign own_req  = req8[MuxSel];
    assign own_last = last8[MuxSel];
    assign BusValid = (state == OWN) && own_req && !Reset;
    assign accept   = BusValid && BusReady;
    assign at_max   = (count + 1'b1) == CW'(MAX_BURST);

    // First requester at or above the pointer, wrapping modulo NREQ.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req8[wrap({1'b0, ptr} + 4'(i))]) begin
                win   = wrap({1'b0, ptr} + 4'(i));
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        grant_n = Grant;
        sel_n   = MuxSel;
        busy_n  = Busy;
        ptr_n   = ptr;
        count_n = count;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = OWN;
                    grant_n = {{(NREQ-1){1'b0}}, 1'b1} << win;
                    sel_n   = win;
                    busy_n  = 1'b1;
                    ptr_n   = wrap({1'b0, win} + 4'd1);
                    count_n = '0;
                end
            end
            OWN: begin
                if (!own_req) begin
                    state_n = TURN;
                    grant_n = '0;
                    busy_n  = 1'b0;
                end else if (accept) begin
                    count_n = count + 1'b1;
                    if (own_last || at_max) begin
                        state_n = TURN;
                        grant_n = '0;
                        busy_n  = 1'b0;
                    end
                end
            end
            TURN: begin
                // MuxSel keeps the previous owner so the mux never glitches.
                state_n = IDLE;
                count_n = '0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            Grant  <= '0;
            MuxSel <= '0;
            Busy   <= 1'b0;
            ptr    <= '0;
            count  <= '0;
        end else begin
            state  <= state_n;
            Grant  <= grant_n;
            MuxSel <= sel_n;
            Busy   <= busy_n;
            ptr    <= ptr_n;
            count  <= count_n;
        end
    end

endmodule

// File: tb/tb_bus_select_arbiter.sv
// Scoreboard bench for bus_select_arbiter: expected tenures are queued by the
// stimulus and checked by a negedge monitor as each grant appears and ends.
module tb_bus_select_arbiter;

    logic       Clk;
    logic       Reset;
    logic [7:0] Req;
    logic [7:0] Last;
    logic       BusReady;
    logic [7:0] Grant;
    logic [2:0] MuxSel;
    logic       BusValid;
    logic       Busy;

    typedef struct {
        logic [7:0] grant;
        logic [2:0] sel;
        int         beats;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;
    int   beats  = 0;
    bit   in_ten = 0;

    bus_select_arbiter #(
        .NREQ(8),
        .MAX_BURST(4)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Req(Req),
        .Last(Last),
        .BusReady(BusReady),
        .Grant(Grant),
        .MuxSel(MuxSel),
        .BusValid(BusValid),
        .Busy(Busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Req   = '0;
        Last  = '0;
        cyc();
        Reset = 1'b0;
    endtask

    task automatic wait_sb(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        chk("wait_sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] s,
                           input logic v, input logic b);
        chk({tag, "_grant"}, 32'(Grant), 32'(g));
        chk({tag, "_muxsel"}, 32'(MuxSel), 32'(s));
        chk({tag, "_busvalid"}, 32'(BusValid), 32'(v));
        chk({tag, "_busy"}, 32'(Busy), 32'(b));
    endtask

    always @(negedge Clk) begin
        if (Reset) begin
            in_ten = 0;
        end else begin
            chk("grant_onehot", 32'($onehot0(Grant)), 32'd1);
            chk("busy_vs_grant", 32'(Busy), 32'(|Grant));
            if (Busy && !in_ten) begin
                in_ten = 1;
                beats  = 0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got %0h, required none", Grant);
                end else begin
                    cur = sb.pop_front();
                    chk("tenure_grant", 32'(Grant), 32'(cur.grant));
                    chk("tenure_muxsel", 32'(MuxSel), 32'(cur.sel));
                end
            end
            if (BusValid && BusReady) beats++;
            if (!Busy && in_ten) begin
                in_ten = 0;
                if (cur.beats >= 0) chk("tenure_beats", 32'(beats), 32'(cur.beats));
                chk("turn_mux_hold", 32'(MuxSel), 32'(cur.sel));
            end
        end
    end

    initial begin
        Reset    = 1'b1;
        Req      = 8'hFF;
        Last     = 8'hFF;
        BusReady = 1'b1;

        // 1: reset holds everything low
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        end
        Reset = 1'b0;
        Req   = '0;
        Last  = '0;
        cyc();

        // 2: single requester, Last on beat 3
        sb.push_back('{8'h04, 3'd2, 3});
        Req = 8'h04;
        cyc();
        chk_out("t2_grant", 8'h04, 3'd2, 1'b1, 1'b1);
        cyc();
        cyc();
        Last = 8'h04;
        cyc();
        chk_out("t2_turn", 8'h00, 3'd2, 1'b0, 1'b0);
        Req  = '0;
        Last = '0;
        cyc();
        cyc();

        // 3: all requesting, single-beat tenures rotate 0..7,0
        do_reset();
        for (int k = 0; k < 9; k++)
            sb.push_back('{8'(8'h01 << (k % 8)), 3'(k % 8), 1});
        Req  = 8'hFF;
        Last = 8'hFF;
        wait_sb(60);
        Req  = '0;
        Last = '0;
        cyc();
        cyc();

        // 4: owner 3 stalled for 5 cycles, Last ignored without BusReady
        sb.push_back('{8'h08, 3'd3, 3});
        Req      = 8'h08;
        BusReady = 1'b1;
        cyc();
        cyc();
        BusReady = 1'b0;
        Last     = 8'h08;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk_out("t4_stall", 8'h08, 3'd3, 1'b1, 1'b1);
        end
        Last     = '0;
        BusReady = 1'b1;
        cyc();
        Last = 8'h08;
        cyc();
        chk_out("t4_release", 8'h00, 3'd3, 1'b0, 1'b0);
        Req  = '0;
        Last = '0;
        cyc();
        cyc();

        // 5: burst limit forces rotation between 0 and 7
        do_reset();
        sb.push_back('{8'h01, 3'd0, 4});
        sb.push_back('{8'h80, 3'd7, 4});
        sb.push_back('{8'h01, 3'd0, 4});
        Req = 8'h81;
        wait_sb(40);
        cyc();
        cyc();
        cyc();
        Req = '0;
        cyc();
        chk_out("t5_done", 8'h00, 3'd0, 1'b0, 1'b0);
        cyc();

        // 6: async reset mid-burst, then pointer restarts at 0
        sb.push_back('{8'h20, 3'd5, -1});
        Req = 8'h20;
        cyc();
        chk_out("t6_grant", 8'h20, 3'd5, 1'b1, 1'b1);
        cyc();
        #1;
        Reset = 1'b1;
        #1;
        chk_out("t6_async", 8'h00, 3'd0, 1'b0, 1'b0);
        Req = '0;
        cyc();
        Reset = 1'b0;
        sb.push_back('{8'h02, 3'd1, 1});
        Req  = 8'h82;
        Last = 8'h02;
        cyc();
        chk_out("t6_ptr0", 8'h02, 3'd1, 1'b1, 1'b1);
        cyc();
        Req  = '0;
        Last = '0;
        cyc();
        cyc();

        // 7: owner abandons without a beat
        sb.push_back('{8'h10, 3'd4, 0});
        Req      = 8'h10;
        BusReady = 1'b0;
        cyc();
        chk_out("t7_grant", 8'h10, 3'd4, 1'b1, 1'b1);
        Req = '0;
        cyc();
        chk_out("t7_abandon", 8'h00, 3'd4, 1'b0, 1'b0);
        cyc();
        cyc();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
